// File: rtl/miriscv_pkg.sv
// Shared MiriSCV definitions: datapath width and memory-request source encoding.
package miriscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

endpackage

// File: rtl/miriscv_arb_tag_fifo.sv
// In-order tag FIFO recording which port owns each outstanding memory transaction,
// with a per-entry discard bit so flushed fetch responses can be swallowed.
module miriscv_arb_tag_fifo
  import miriscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             push,
  input  logic             push_src,
  input  logic             pop,
  input  logic             flush_mark,
  output logic             head_src,
  output logic             head_discard,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] src_q;
  logic [DEPTH-1:0] discard_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign do_push      = push & ~full;
  assign do_pop       = pop & ~empty;
  assign head_src     = src_q[rd_ptr];
  assign head_discard = discard_q[rd_ptr];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_q   <= '0;
      src_q     <= '0;
      discard_q <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A fresh push never lands on the slot being popped: no push while full.
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && wr_ptr == PTR_W'(i)) begin
          valid_q[i]   <= 1'b1;
          src_q[i]     <= push_src;
          discard_q[i] <= flush_mark && (push_src == SRC_INSTR);
        end else begin
          if (do_pop && rd_ptr == PTR_W'(i)) valid_q[i] <= 1'b0;
          if (flush_mark && valid_q[i] && src_q[i] == SRC_INSTR) discard_q[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the fetch and LSU ports,
// routing in-order responses back via the tag FIFO.
module miriscv_mem_arbiter
  import miriscv_pkg::*;
#(
  parameter int XLEN      = miriscv_pkg::XLEN,
  parameter int MAX_OUTST = 2
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            instr_req_i,
  input  logic [XLEN-1:0] instr_addr_i,
  output logic            instr_gnt_o,
  output logic            instr_rvalid_o,
  output logic [XLEN-1:0] instr_rdata_o,
  input  logic            instr_flush_i,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic [XLEN-1:0] data_wdata_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  output logic [XLEN-1:0] data_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            resp_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  src_e             sel;
  src_e             last_q;
  logic             accept;
  logic             pop;
  logic             full;
  logic             empty;
  logic             head_src;
  logic             head_discard;
  logic [CNT_W-1:0] count;

  // On contention the source that did not win last time gets the port.
  always_comb begin
    sel = SRC_INSTR;
    if (instr_req_i && data_req_i) sel = (last_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    else if (data_req_i)           sel = SRC_DATA;
  end

  assign mem_req_o   = (instr_req_i | data_req_i) & ~full;
  assign accept      = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = accept & (sel == SRC_INSTR);
  assign data_gnt_o  = accept & (sel == SRC_DATA);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'hF;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (sel == SRC_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)    last_q <= SRC_INSTR;
    else if (accept) last_q <= sel;
  end

  miriscv_arb_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .push         (accept),
    .push_src     (sel),
    .pop          (pop),
    .flush_mark   (instr_flush_i),
    .head_src     (head_src),
    .head_discard (head_discard),
    .full         (full),
    .empty        (empty),
    .count        (count)
  );

  assign pop            = mem_rvalid_i & ~empty;
  assign data_rvalid_o  = pop & (head_src == SRC_DATA);
  assign instr_rvalid_o = pop & (head_src == SRC_INSTR) & ~head_discard;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  // A response with nothing outstanding is unattributable; flag it instead of routing.
  assign resp_err_o     = mem_rvalid_i & (count == '0);

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed and randomized checks of the memory arbiter against a queue-based model.
module tb_miriscv_mem_arbiter;
  import miriscv_pkg::*;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        instr_req = 1'b0, instr_gnt, instr_rvalid, instr_flush = 1'b0;
  logic [31:0] instr_addr = '0, instr_rdata;
  logic        data_req = 1'b0, data_we = 1'b0, data_gnt, data_rvalid;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
  logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0, resp_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

  always #5 clk = ~clk;

  miriscv_mem_arbiter #(.XLEN(32), .MAX_OUTST(MAXO)) dut (
    .clk_i(clk), .arstn_i(arstn),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_flush_i(instr_flush),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .resp_err_o(resp_err)
  );

  typedef struct {bit is_data; bit disc;} tag_t;
  tag_t q[$];
  bit   last_data;
  int   checks = 0;
  int   failures = 0;
  bit   exp_ig, exp_dg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; expectations come from the outstanding-tag queue model.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                      input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                      input bit g, input bit rv, input logic [31:0] rd, input bit fl);
    bit   full, ereq, sdata, acc, pop;
    tag_t h = '{0, 0};
    @(negedge clk);
    instr_req = ir; instr_addr = ia; data_req = dr; data_we = dwe; data_be = dbe;
    data_addr = da; data_wdata = dwd; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
    instr_flush = fl;
    #1;
    full  = q.size() >= MAXO;
    ereq  = (ir || dr) && !full;
    sdata = dr && (!ir || !last_data);
    acc   = ereq && g;
    exp_ig = acc && !sdata;
    exp_dg = acc && sdata;
    pop   = rv && q.size() > 0;
    if (pop) h = q[0];
    chk("mem_req", mem_req, ereq);
    chk("instr_gnt", instr_gnt, exp_ig);
    chk("data_gnt", data_gnt, exp_dg);
    if (ereq) begin
      chk("mem_we", mem_we, sdata ? dwe : 1'b0);
      chk("mem_be", mem_be, sdata ? dbe : 4'hF);
      chk("mem_addr", mem_addr, sdata ? da : ia);
      chk("mem_wdata", mem_wdata, sdata ? dwd : 32'h0);
    end
    chk("instr_rvalid", instr_rvalid, pop && !h.is_data && !h.disc);
    chk("data_rvalid", data_rvalid, pop && h.is_data);
    chk("resp_err", resp_err, rv && !pop);
    if (pop) begin
      chk("instr_rdata", instr_rdata, rd);
      chk("data_rdata", data_rdata, rd);
    end
    if (acc) $display("t=%0t accept %s addr=%h", $time, sdata ? "data " : "instr", sdata ? da : ia);
    if (rv) $display("t=%0t resp %s rdata=%h", $time,
                     !pop ? "unexpected" : h.is_data ? "data" : h.disc ? "instr(discarded)" : "instr", rd);
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back('{sdata, 0});
      last_data = sdata;
    end
    if (fl) foreach (q[i]) if (!q[i].is_data) q[i].disc = 1;
  endtask

  task automatic fetch(input logic [31:0] a, input bit rv, input logic [31:0] rd, input bit fl);
    step(1, a, 0, 0, 4'h0, 32'h0, 32'h0, 1, rv, rd, fl);
  endtask

  task automatic idle(input bit rv, input logic [31:0] rd, input bit fl);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, rv, rd, fl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arstn = 1'b0;
    instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 0; instr_flush = 0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_gnt", {instr_gnt, data_gnt}, 2'b00);
    chk("rst_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
    chk("rst_resp_err", resp_err, 1'b0);
    q.delete();
    last_data = 0;
    @(negedge clk);
    arstn = 1'b1;
  endtask

  initial begin
    bit          pi, pd, dwe, g, rv, fl;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    do_reset();

    // Contention after reset: data first, then instruction; responses route in order.
    step(1, 32'h100, 1, 1, 4'h3, 32'h200, 32'hCAFE0001, 1, 0, 32'h0, 0);
    step(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h11111111, 0);
    idle(1, 32'h22222222, 0);

    // Continuous contention with one-cycle latency: grants alternate.
    for (int i = 0; i < 8; i++)
      step(1, 32'h400 + 32'(i * 4), 1, 0, 4'hF, 32'h800 + 32'(i * 4), 32'h0, 1, i != 0, 32'(i), 0);
    idle(1, 32'h0, 0);

    // Withheld responses: port closes at MAX_OUTST, reopens the cycle after a pop.
    fetch(32'h10, 0, 32'h0, 0);
    fetch(32'h14, 0, 32'h0, 0);
    fetch(32'h18, 0, 32'h0, 0);
    fetch(32'h18, 1, 32'hA5A5A5A5, 0);
    fetch(32'h1C, 1, 32'h5A5A5A5A, 0);
    idle(1, 32'h1, 0);
    idle(1, 32'h2, 0);

    // Flushed fetches are swallowed; a later fetch is delivered.
    fetch(32'h20, 0, 32'h0, 0);
    fetch(32'h24, 0, 32'h0, 0);
    idle(0, 32'h0, 1);
    idle(1, 32'hDEADBEEF, 0);
    idle(1, 32'h12345678, 0);
    fetch(32'h28, 0, 32'h0, 0);
    idle(1, 32'h00000013, 0);

    // Stray response with nothing outstanding.
    idle(1, 32'hBAD0BAD0, 0);
    idle(0, 32'h0, 0);

    // Reset with two outstanding: late response is stray, next request granted.
    fetch(32'h30, 0, 32'h0, 0);
    step(0, 32'h0, 1, 1, 4'hF, 32'h34, 32'h77, 1, 0, 32'h0, 0);
    do_reset();
    idle(1, 32'h0BADF00D, 0);
    fetch(32'h38, 0, 32'h0, 0);
    idle(1, 32'h44444444, 0);

    // Randomized traffic, requesters hold payload until granted.
    pi = 0; pd = 0; ia = 0; da = 0; dwd = 0; dwe = 0; dbe = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1; ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1; da = $urandom; dwd = $urandom; dwe = 1'($urandom); dbe = 4'($urandom);
      end
      g  = $urandom_range(0, 3) != 0;
      rv = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      fl = $urandom_range(0, 7) == 0;
      step(pi, ia, pd, dwe, dbe, da, dwd, g, rv, $urandom, fl);
      if (exp_ig) pi = 0;
      if (exp_dg) pd = 0;
    end
    for (int n = 0; n < 8 && q.size() > 0; n++) idle(1, $urandom, 0);
    idle(1, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miriscv_mem_arbiter.md
MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default miriscv_pkg::XLEN (32), address/data width.
REQ-002 SHALL have parameter MAX_OUTST, default 2, max accepted-but-unanswered transactions (range 1..4).
REQ-003 SHALL have clk_i  in  1  clock; arstn_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have instr_req_i in 1, instr_addr_i in XLEN, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out XLEN (fetch port, read-only).
REQ-005 SHALL have instr_flush_i  in  1  discard all outstanding fetch responses (driven by control-unit kill/force).
REQ-006 SHALL have data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in XLEN, data_wdata_i in XLEN, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out XLEN (LSU port).
REQ-007 SHALL have mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out XLEN, mem_wdata_o out XLEN, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in XLEN (shared memory port).
REQ-008 SHALL have resp_err_o  out  1  one-cycle pulse on mem_rvalid_i with no outstanding transaction.

Function
REQ-009 Requesters SHALL hold req and payload stable until their gnt is seen; a transaction is accepted in the cycle mem_req_o & mem_gnt_i.
REQ-010 mem_req_o SHALL be (instr_req_i | data_req_i) & ~full, combinational; full = outstanding count == MAX_OUTST (no same-cycle pop bypass).
REQ-011 Selection SHALL be 2-way round-robin: sole requester wins; on contention the source not granted last wins; last-grant pointer updates only on acceptance.
REQ-012 mem_* payload SHALL mux from the selected source; instruction selection drives mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-013 instr_gnt_o/data_gnt_o SHALL equal selected & mem_req_o & mem_gnt_i; never both high.
REQ-014 On acceptance the source tag (instr/data) SHALL be pushed into an in-order tag FIFO of depth MAX_OUTST with discard bit 0.
REQ-015 Memory SHALL return exactly one mem_rvalid_i per accepted transaction (writes included), in order, earliest one cycle after acceptance.
REQ-016 On mem_rvalid_i with FIFO non-empty the head SHALL pop; data tag -> data_rvalid_o=1 same cycle; instr tag with discard=0 -> instr_rvalid_o=1 same cycle; discard=1 -> no valid issued.
REQ-017 *_rdata_o SHALL be mem_rdata_i passed combinationally; value irrelevant when corresponding rvalid=0.
REQ-018 instr_flush_i SHALL set discard on every valid instr-tagged entry, including one pushed in the same cycle; data entries untouched.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo MAX_OUTST.
REQ-020 mem_rvalid_i with empty FIFO SHALL be ignored for routing and pulse resp_err_o for one cycle.

Reset
REQ-021 arstn_i low SHALL clear count, FIFO pointers, discard bits, resp_err_o, and set last-grant pointer to instr (data wins first contention).
REQ-022 Mid-transaction reset SHALL drop all outstanding tags; responses arriving after reset are treated per REQ-020.
REQ-023 Outputs during reset: all gnt/rvalid/mem_req_o/resp_err_o 0 (given requests are 0 or FIFO logic cleared).

Structure
REQ-024 XLEN SHALL come from miriscv_pkg; a 1-bit source enum (SRC_INSTR, SRC_DATA) SHALL be added to miriscv_pkg.
REQ-025 The tag FIFO SHALL be a sub-module miriscv_arb_tag_fifo (push, pop, flush-mark, head, full, empty, count); arbitration and muxing stay in top.

Verification
REQ-026 Both req at 0x100(instr)/0x200(data write, be=4'h3) after reset, mem_gnt_i=1 -> data granted cycle 0, instr cycle 1; rvalids route data then instr.
REQ-027 Continuous contention 8 cycles, mem_gnt_i=1, latency 1, MAX_OUTST=2 -> grants alternate D,I,D,I...; no source waits >1 grant.
REQ-028 mem_gnt_i=1, responses withheld -> after 2 acceptances mem_req_o=0; first mem_rvalid_i frees slot, next cycle mem_req_o=1.
REQ-029 Two fetches outstanding, instr_flush_i pulse, then 2 responses 0xDEADBEEF/0x12345678 -> instr_rvalid_o stays 0; a third fetch's response 0x00000013 is delivered.
REQ-030 mem_rvalid_i with nothing outstanding -> resp_err_o=1 one cycle, no rvalid output.
REQ-031 Reset asserted with 2 outstanding, released -> count 0, late rvalid flagged per REQ-020, next request granted normally.
